// File: rtl/mem_port_arbiter_if.sv
// Simple memory request/response bundle shared by requesters and the
// downstream port. master drives the request fields, slave the response.
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic            ready;
  logic            valid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    output wstrb,
    input  ready,
    input  valid,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    input  wstrb,
    output ready,
    output valid,
    output rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Core/debug arbiter for a single memory port: one outstanding
// transaction, round-robin or debug-priority, sticky watchdog flag.
module mem_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int DBG_PRIORITY   = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  c_if,
  mem_port_arbiter_if.slave  d_if,
  mem_port_arbiter_if.master m_if,
  output logic               owner,
  output logic               busy,
  output logic               timeout_flag,
  input  logic               timeout_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [XLEN-1:0]   m_addr_q, m_addr_d;
  logic [XLEN-1:0]   m_wdata_q, m_wdata_d;
  logic [3:0]        m_wstrb_q, m_wstrb_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flag_q, flag_d;

  logic              any_req;
  logic              win;
  logic              flag_set;
  logic              ready_p;
  logic              valid_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wstrb_q    <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      flag_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wstrb_q    <= m_wstrb_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      flag_q       <= flag_d;
    end
  end

  // win: 0 = core, 1 = debug
  always_comb begin
    any_req = c_if.req | d_if.req;
    win     = 1'b0;
    unique case (1'b1)
      (c_if.req && !d_if.req): win = 1'b0;
      (!c_if.req && d_if.req): win = 1'b1;
      (c_if.req && d_if.req):
        win = (DBG_PRIORITY != 0) ? 1'b1 : ~last_owner_q;
      default:                 win = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wstrb_d    = m_wstrb_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    flag_set     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = ISSUE;
          m_req_d      = 1'b1;
          m_we_d       = win ? d_if.we    : c_if.we;
          m_addr_d     = win ? d_if.addr  : c_if.addr;
          m_wdata_d    = win ? d_if.wdata : c_if.wdata;
          m_wstrb_d    = win ? d_if.wstrb : c_if.wstrb;
          owner_d      = win;
          last_owner_d = win;
          cnt_d        = '0;
        end
      end
      ISSUE: begin
        if (m_if.ready) begin
          m_req_d = 1'b0;
          state_d = m_if.valid ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (m_if.valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flag fires only on the step onto the limit, not while saturated
    if (state_q != IDLE && cnt_q != TMO) begin
      cnt_d    = cnt_q + 1'b1;
      flag_set = (cnt_q == TMO - 1'b1);
    end

    flag_d = flag_set | (flag_q & ~timeout_clr);
  end

  always_comb begin
    ready_p = (state_q == ISSUE) && m_if.ready;
    valid_p = (ready_p && m_if.valid) ||
              ((state_q == WAIT) && m_if.valid);
  end

  assign c_if.ready  = ready_p & ~owner_q;
  assign d_if.ready  = ready_p & owner_q;
  assign c_if.valid  = valid_p & ~owner_q;
  assign d_if.valid  = valid_p & owner_q;
  assign c_if.rdata  = (valid_p && !owner_q) ? m_if.rdata : '0;
  assign d_if.rdata  = (valid_p && owner_q)  ? m_if.rdata : '0;

  assign m_if.req    = m_req_q;
  assign m_if.we     = m_we_q;
  assign m_if.addr   = m_addr_q;
  assign m_if.wdata  = m_wdata_q;
  assign m_if.wstrb  = m_wstrb_q;

  assign owner        = owner_q;
  assign busy         = (state_q != IDLE);
  assign timeout_flag = flag_q;

endmodule
